// File: rtl/mac_pkg.sv
// Shared constants and types for the mac_v5 streaming multiply-accumulate unit.
package mac_pkg;

    localparam int IN_W_DEF  = 4;
    localparam int GROUP_DEF = 4;
    localparam int OUT_W_DEF = 10;

    // A group of one still needs a 1-bit counter to stay a legal vector.
    localparam int CNT_W_DEF = (GROUP_DEF > 1) ? $clog2(GROUP_DEF) : 1;

    typedef logic [IN_W_DEF-1:0]  operand_t;
    typedef logic [OUT_W_DEF-1:0] result_t;

endpackage

// File: rtl/mac_mult.sv
// Combinational unsigned IN_W x IN_W multiplier with a full-width 2*IN_W product.
module mac_mult #(
    parameter int IN_W = 4
) (
    input  logic [IN_W-1:0]   a,
    input  logic [IN_W-1:0]   b,
    output logic [2*IN_W-1:0] product
);

    logic [2*IN_W-1:0] a_ext;
    logic [2*IN_W-1:0] b_ext;

    assign a_ext   = {{IN_W{1'b0}}, a};
    assign b_ext   = {{IN_W{1'b0}}, b};
    assign product = a_ext * b_ext;

endmodule

// File: rtl/mac_v5.sv
// Streaming dot product over GROUP valid operand pairs, one registered result per group.
// Optional MAC_HOLD_OUT_EN: out keeps the last result while out_valid is low.
module mac_v5
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int GROUP = GROUP_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in1_IFM,
    input  logic [IN_W-1:0]  in2_IFM,
    output logic             out_valid,
    output logic [OUT_W-1:0] out
);

    localparam int CNT_W = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUP - 1);

    logic [2*IN_W-1:0] product;
    logic [OUT_W-1:0]  product_ext;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  result;
    logic [CNT_W-1:0]  cnt;
    logic              valid_q;

    mac_mult #(
        .IN_W(IN_W)
    ) u_mult (
        .a      (in1_IFM),
        .b      (in2_IFM),
        .product(product)
    );

    assign product_ext = OUT_W'(product);

    // in_valid alone qualifies a pair: no ready exists, so every cycle with
    // in_valid=1 is consumed on that edge and operands are ignored otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            result  <= '0;
            valid_q <= 1'b0;
        end else if (in_valid) begin
            if (cnt == LAST) begin
                result  <= acc + product_ext;
                valid_q <= 1'b1;
                acc     <= '0;
                cnt     <= '0;
            end else begin
                // Sample 0 starts fresh so nothing leaks from a previous group.
                acc     <= (cnt == '0) ? product_ext : acc + product_ext;
                cnt     <= cnt + CNT_W'(1);
                valid_q <= 1'b0;
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;

`ifdef MAC_HOLD_OUT_EN
    assign out = result;
`else
    assign out = valid_q ? result : '0;
`endif

endmodule

// File: tb/tb_mac_v5.sv
// Directed self-checking bench for mac_v5 (default GROUP=4, IN_W=4, OUT_W=10).
module tb_mac_v5;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in1_IFM;
    logic [3:0] in2_IFM;
    logic       out_valid;
    logic [9:0] out;

    int checks = 0;
    int errors = 0;

    mac_v5 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in1_IFM  (in1_IFM),
        .in2_IFM  (in2_IFM),
        .out_valid(out_valid),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one valid pair across one rising edge, then returns 1 time unit after it.
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1;
        in1_IFM  = a;
        in2_IFM  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1_IFM  = 'x;
        in2_IFM  = 'x;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in1_IFM  = 'x;
        in2_IFM  = 'x;
        idle(2);
        check("reset_out", 16'(out), 16'd0);
        check("reset_valid", 16'(out_valid), 16'd0);
        rst_n = 1'b1;
        idle(1);

        // Basic group: 2+12+30+56 = 100
        send(4'd1, 4'd2);
        send(4'd3, 4'd4);
        send(4'd5, 4'd6);
        check("basic_no_early_valid", 16'(out_valid), 16'd0);
        send(4'd7, 4'd8);
        check("basic_valid", 16'(out_valid), 16'd1);
        check("basic_out", 16'(out), 16'd100);
        idle(1);
        check("basic_valid_drop", 16'(out_valid), 16'd0);
`ifdef MAC_HOLD_OUT_EN
        check("basic_out_hold", 16'(out), 16'd100);
`else
        check("basic_out_zero", 16'(out), 16'd0);
`endif

        // Max operands: 4*225 = 900, no wrap
        for (int i = 0; i < 4; i++) send(4'd15, 4'd15);
        check("max_valid", 16'(out_valid), 16'd1);
        check("max_out", 16'(out), 16'd900);
        idle(1);

        // Gapped group: 6+20+1+0 = 27
        send(4'd2, 4'd3);
        idle(1);
        check("gap_valid_a", 16'(out_valid), 16'd0);
        idle(1);
        check("gap_valid_b", 16'(out_valid), 16'd0);
        send(4'd4, 4'd5);
        idle(1);
        check("gap_valid_c", 16'(out_valid), 16'd0);
        send(4'd1, 4'd1);
        check("gap_valid_d", 16'(out_valid), 16'd0);
        send(4'd0, 4'd9);
        check("gap_valid", 16'(out_valid), 16'd1);
        check("gap_out", 16'(out), 16'd27);
        idle(1);

        // Back-to-back: 4*(2*2)=16 then 4*(3*1)=12, strobes 4 cycles apart
        for (int i = 0; i < 4; i++) send(4'd2, 4'd2);
        check("b2b_first_valid", 16'(out_valid), 16'd1);
        check("b2b_first_out", 16'(out), 16'd16);
        for (int i = 0; i < 3; i++) begin
            send(4'd3, 4'd1);
            check("b2b_between_valid", 16'(out_valid), 16'd0);
        end
        send(4'd3, 4'd1);
        check("b2b_second_valid", 16'(out_valid), 16'd1);
        check("b2b_second_out", 16'(out), 16'd12);

        // Asynchronous reset while a strobe is showing
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 16'(out), 16'd0);
        check("async_rst_valid", 16'(out_valid), 16'd0);
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(4'd1, 4'd1);
        check("post_rst_valid", 16'(out_valid), 16'd1);
        check("post_rst_out", 16'(out), 16'd4);
        idle(1);

        // Reset mid-group discards the 2*225 partial sum
        send(4'd15, 4'd15);
        send(4'd15, 4'd15);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send(4'd1, 4'd3);
        check("midrst_no_early_valid", 16'(out_valid), 16'd0);
        send(4'd1, 4'd3);
        check("midrst_valid", 16'(out_valid), 16'd1);
        check("midrst_out", 16'(out), 16'd12);
        idle(2);
        check("midrst_valid_drop", 16'(out_valid), 16'd0);
`ifdef MAC_HOLD_OUT_EN
        check("midrst_out_hold", 16'(out), 16'd12);
`else
        check("midrst_out_zero", 16'(out), 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
